// File: rtl/apb4_regfile_if.sv
// APB4 bus bundle between a master (bridge/decoder or testbench) and the
// register-file slave.
//   PADDR/PWRITE/PWDATA/PSTRB/PSELx/PENABLE : master -> slave
//   PRDATA/PREADY/PSLVERR                   : slave  -> master
interface apb4_regfile_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0]   PADDR;
    logic                    PWRITE;
    logic [DATA_WIDTH-1:0]   PWDATA;
    logic [DATA_WIDTH/8-1:0] PSTRB;
    logic                    PSELx;
    logic                    PENABLE;
    logic [DATA_WIDTH-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    modport master (
        output PADDR, PWRITE, PWDATA, PSTRB, PSELx, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWRITE, PWDATA, PSTRB, PSELx, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb4_regfile_slave.sv
// Parametrised APB4 register-file slave with byte-lane writes, programmable
// wait states and read-only registers sourced from hardware status inputs.
//   i_clk, i_reset_n : clock, synchronous active-low reset
//   apb              : APB4 slave port (see apb4_regfile_if)
//   i_ro_data        : hardware values for read-only registers, slice i per register
//   o_regs           : current RW register contents, read-only slices read 0
//
// state  | meaning
// IDLE   | no transfer; waiting for a setup phase (PSELx=1, PENABLE=0)
// ACCESS | access phase; counting wait states, then executing the transfer
// DONE   | PREADY/PSLVERR presented for exactly one cycle
module apb4_regfile_slave #(
    parameter int                DATA_WIDTH  = 32,
    parameter int                ADDR_WIDTH  = 12,
    parameter int                NUM_REGS    = 8,
    parameter int                WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK   = '0
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    apb4_regfile_if.slave                  apb,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] i_ro_data,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs
);
    localparam int NB   = DATA_WIDTH / 8;
    localparam int LSB  = $clog2(NB);
    localparam int IDXB = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] prdata_q;
    logic                  pready_q;
    logic                  pslverr_q;

    logic [ADDR_WIDTH:0]   index_full;
    logic [IDXB-1:0]       idx_sel;
    logic                  out_of_range;
    logic                  misaligned;
    logic                  is_ro;
    logic                  err;
    logic [DATA_WIDTH-1:0] rd_val;

    // Extra top bit keeps the range compare valid even when every address maps.
    assign index_full   = {1'b0, apb.PADDR} >> LSB;
    assign idx_sel      = index_full[IDXB-1:0];
    assign out_of_range = index_full >= (ADDR_WIDTH+1)'(NUM_REGS);

    generate
        if (LSB > 0) begin : g_align
            assign misaligned = |apb.PADDR[LSB-1:0];
        end else begin : g_no_align
            assign misaligned = 1'b0;
        end
    endgenerate

    // idx_sel may alias for out-of-range indices; err masks those cases.
    always_comb begin
        rd_val = '0;
        is_ro  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_sel == IDXB'(i)) begin
                is_ro  = RO_MASK[i];
                rd_val = RO_MASK[i] ? i_ro_data[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
            end
        end
    end

    assign err = out_of_range | misaligned | (apb.PWRITE & is_ro);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    // PENABLE without a preceding setup phase is ignored here.
                    if (apb.PSELx && !apb.PENABLE) begin
                        cnt   <= 4'(WAIT_STATES);
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!apb.PSELx) begin
                        state <= IDLE;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        pready_q  <= 1'b1;
                        pslverr_q <= err;
                        state     <= DONE;
                        if (apb.PWRITE) begin
                            if (!err) begin
                                for (int i = 0; i < NUM_REGS; i++) begin
                                    for (int b = 0; b < NB; b++) begin
                                        if (idx_sel == IDXB'(i) && apb.PSTRB[b]) begin
                                            regs_q[i][8*b +: 8] <= apb.PWDATA[8*b +: 8];
                                        end
                                    end
                                end
                            end
                        end else begin
                            prdata_q <= err ? '0 : rd_val;
                        end
                    end
                end
                DONE: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
            assign o_regs[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs_q[i];
        end
    endgenerate
endmodule
